color_serializer: RTL

Transmit-side counterpart to the keypad colour entry path. Takes a 24-bit RGB colour and emits it as six 4-bit hex digits, most-significant first. Each digit is sent over a valid/next handshake to a digit consumer, such as the seven-segment echo or a serial link. Sits between the main state machine, which holds the current R,G,B, and any per-digit output stage.

---
 rtl/color_serializer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/color_serializer.sv
// color_serializer: sends a 24-bit RGB colour as hex digits, MS nibble first,
// over a valid/next handshake. All outputs come straight from registers.
module color_serializer #(
   parameter int NUM_DIGITS  = 6,
   parameter int DIGIT_WIDTH = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] color,
   input  logic                              start,
   input  logic                              abort,
   input  logic                              next,
   output logic [DIGIT_WIDTH-1:0]            digit,
   output logic                              valid,
   output logic [2:0]                        index,
   output logic                              busy,
   output logic                              done
);

   localparam int COLOR_WIDTH = NUM_DIGITS * DIGIT_WIDTH;
   localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_DONE
   } state_t;

   state_t                 r_state;
   logic [COLOR_WIDTH-1:0] r_shift;
   logic [DIGIT_WIDTH-1:0] r_digit;
   logic                   r_valid;
   logic [2:0]             r_index;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_xfer;
   logic                   w_last;
   logic [DIGIT_WIDTH-1:0] w_first_digit;
   logic [DIGIT_WIDTH-1:0] w_next_digit;

   // handshake decode and nibble selection
   always_comb begin
      w_xfer        = r_valid & next;
      w_last        = (r_index == LAST_IDX);
      w_first_digit = color[COLOR_WIDTH-1 -: DIGIT_WIDTH];
      // nibble that becomes the top one after this shift
      w_next_digit  = r_shift[COLOR_WIDTH-DIGIT_WIDTH-1 -: DIGIT_WIDTH];
   end

   // transfer FSM with registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_digit <= '0;
         r_valid <= 1'b0;
         r_index <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               // abort and next have no meaning here; start wins
               if (start) begin
                  r_shift <= color;
                  r_digit <= w_first_digit;
                  r_valid <= 1'b1;
                  r_index <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               if (abort) begin
                  // cancel beats any accept in the same cycle
                  r_shift <= '0;
                  r_digit <= '0;
                  r_valid <= 1'b0;
                  r_index <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
                  r_state <= S_IDLE;
               end else if (w_xfer) begin
                  if (w_last) begin
                     r_shift <= '0;
                     r_digit <= '0;
                     r_valid <= 1'b0;
                     r_index <= '0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_shift <= r_shift << DIGIT_WIDTH;
                     r_digit <= w_next_digit;
                     r_index <= r_index + 3'd1;
                  end
               end
            end
            S_DONE: begin
               // single-cycle completion pulse; start is not sampled here
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_shift <= '0;
               r_digit <= '0;
               r_valid <= 1'b0;
               r_index <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign digit = r_digit;
   assign valid = r_valid;
   assign index = r_index;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule
